// File: rtl/line_writeback_ctrl_pkg.sv
// Shared cache constants, writeback FSM encoding and the
// memory address composition helper.
package line_writeback_ctrl_pkg;

    localparam int WORD_W     = 32;
    localparam int WORDS      = 16;
    localparam int TAG_W      = 25;
    localparam int INDEX_W    = 1;
    localparam int BYTE_OFF_W = 2;
    localparam int CNT_W      = $clog2(WORDS);
    localparam int BLOCK_W    = WORDS * WORD_W;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } wbState_t;

    function automatic logic [31:0] composeAddr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] index,
        input logic [CNT_W-1:0]   word
    );
        return {tag, index, word, {BYTE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/line_writeback_ctrl_wb_word_buffer.sv
// Victim block capture register with a word-select read port
// indexed by the beat counter.
module wb_word_buffer
    import line_writeback_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [BLOCK_W-1:0] blockIn,
    input  logic [CNT_W-1:0]   sel,
    output logic [WORD_W-1:0]  wordOut
);

    logic [BLOCK_W-1:0] lineReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lineReg <= '0;
        end else if (load) begin
            lineReg <= blockIn;
        end
    end

    assign wordOut = lineReg[sel*WORD_W +: WORD_W];

endmodule

// File: rtl/line_writeback_ctrl.sv
// Dirty-line eviction engine: captures a victim line and streams
// it to memory as one word per valid/ready beat.
module line_writeback_ctrl
    import line_writeback_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               evictReq,
    output logic               evictReady,
    input  logic [BLOCK_W-1:0] victimBlock,
    input  logic [TAG_W-1:0]   victimTag,
    input  logic [INDEX_W-1:0] victimIndex,
    input  logic               victimValid,
    input  logic               victimDirty,
    output logic               memValid,
    input  logic               memReady,
    output logic [31:0]        memAddr,
    output logic [WORD_W-1:0]  memData,
    output logic               memLast,
    output logic               wbDone,
    output logic               busy
);

    wbState_t           state;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   tagReg;
    logic [INDEX_W-1:0] indexReg;
    logic               acceptDirty;

    assign acceptDirty = (state == IDLE) && evictReq
                       && victimValid && victimDirty;

    wb_word_buffer uBuffer (
        .clk     (clk),
        .reset   (reset),
        .load    (acceptDirty),
        .blockIn (victimBlock),
        .sel     (cnt),
        .wordOut (memData)
    );

    assign memAddr = composeAddr(tagReg, indexReg, cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tagReg     <= '0;
            indexReg   <= '0;
            evictReady <= 1'b1;
            memValid   <= 1'b0;
            memLast    <= 1'b0;
            wbDone     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (evictReq) begin
                        evictReady <= 1'b0;
                        busy       <= 1'b1;
                        if (victimValid && victimDirty) begin
                            tagReg   <= victimTag;
                            indexReg <= victimIndex;
                            cnt      <= '0;
                            memValid <= 1'b1;
                            memLast  <= 1'b0;
                            state    <= SEND;
                        end else begin
                            wbDone <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (memReady) begin
                        if (cnt == LAST_WORD) begin
                            cnt      <= '0;
                            memValid <= 1'b0;
                            memLast  <= 1'b0;
                            wbDone   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            // flag the final beat as the counter reaches it
                            memLast <= (cnt == LAST_WORD - 1'b1);
                        end
                    end
                end
                DONE: begin
                    wbDone     <= 1'b0;
                    busy       <= 1'b0;
                    evictReady <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    memValid   <= 1'b0;
                    memLast    <= 1'b0;
                    wbDone     <= 1'b0;
                    busy       <= 1'b0;
                    evictReady <= 1'b1;
                end
            endcase
        end
    end

endmodule
